// File: rtl/mem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and owner codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester winner select (CPU control unit vs I/O port).
// Default build: round-robin on a tie, the requester that is not last_owner wins.
// MEM_ARB_FIXED_PRIO_EN defined: the CPU always wins a tie and last_owner is unused.
import mem_arb_pkg::*;

module arb_pick2 (
    input  logic cpu_req,
    input  logic io_req,
    input  logic last_owner,
    output logic win_valid,
    output logic win_owner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Pick the winner for this cycle; a lone requester always wins.
    always_comb begin
        win_valid = cpu_req | io_req;
        win_owner = OWN_CPU;
        if (cpu_req && io_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            win_owner = OWN_CPU;
`else
            win_owner = (last_owner == OWN_CPU) ? OWN_IO : OWN_CPU;
`endif
        end else if (io_req) begin
            win_owner = OWN_IO;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter between the CPU control unit and the I/O port.
// req/gnt/done handshake per requester, latched memory address/data/we,
// registered read data. Tie policy selected by MEM_ARB_FIXED_PRIO_EN
// (undefined: round-robin, defined: CPU fixed priority).
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // WAIT spans MEM_LAT-1 cycles: load MEM_LAT-2 and leave when the counter reads 0.
    localparam logic [3:0] WAIT_LOAD = 4'((MEM_LAT >= 2) ? MEM_LAT - 2 : 0);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [3:0]    cnt_q,   cnt_d;
    logic          we_q,    we_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic win_valid;
    logic win_owner;

    arb_pick2 u_pick (
        .cpu_req    (cpu_req),
        .io_req     (io_req),
        .last_owner (owner_q),
        .win_valid  (win_valid),
        .win_owner  (win_owner)
    );

    // Next-state, grant latching, wait countdown and read capture.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // variable unassigned; otherwise synthesis would infer latches.
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = ACCESS;
                    owner_d = win_owner;
                    if (win_owner == OWN_CPU) begin
                        addr_d  = cpu_addr;
                        we_d    = cpu_we;
                        wdata_d = cpu_wdata;
                    end else begin
                        addr_d  = io_addr;
                        we_d    = io_we;
                        wdata_d = io_wdata;
                    end
                end
            end
            ACCESS: begin
                if (MEM_LAT == 1) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = mem_rdata;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset returns to IDLE with IO as last owner.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before the edge, independent of statement order.
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IO;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: strobes and handshakes are decoded from the asynchronously reset
    // state, so asserting rst drops them at once instead of at the next edge.
    assign busy      = (state_q != IDLE);
    assign cpu_gnt   = busy && (owner_q == OWN_CPU);
    assign io_gnt    = busy && (owner_q == OWN_IO);
    assign cpu_done  = (state_q == DONE) && (owner_q == OWN_CPU);
    assign io_done   = (state_q == DONE) && (owner_q == OWN_IO);
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: the CPU control unit (instruction fetch, RD, WR) and the I/O port requester.
- Each requester uses a req/gnt/done handshake.
- The block owns the memory address, data and write-enable pins, and returns read data on a shared registered bus.
- It sits between the control unit/I/O block and the memory.

Parameters:
- AW, 8, memory address width.
- DW, 8, memory data width.
- MEM_LAT, 1, memory access cycles, counted from the ACCESS cycle. Legal range 1..15. 1 = asynchronous-read memory; 2 = registered-read memory.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request; held until cpu_done.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU owns the memory.
- cpu_done  out  1  one-cycle CPU completion pulse.
- io_req  in  1  I/O request; held until io_done.
- io_we  in  1  I/O write/read.
- io_addr  in  AW  I/O address.
- io_wdata  in  DW  I/O write data.
- io_gnt  out  1  I/O owns the memory.
- io_done  out  1  one-cycle I/O completion pulse.
- rdata  out  DW  registered read data; valid while the matching done is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=IO (so the CPU wins the first tie), wait counter=0.
  - All outputs 0, including rdata, mem_addr and mem_wdata.
  - Reset during any state aborts the transaction immediately; mem_en and mem_we drop without waiting for a clock. No done is issued for the aborted transaction.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester that is not the stored owner (round-robin).
  - On the grant edge: record owner; latch that requester's addr/we/wdata into mem_addr/mem_we-source/mem_wdata; go to ACCESS.
- ACCESS (1 cycle):
  - mem_en=1; mem_we=latched we.
  - The selected gnt is high from ACCESS through DONE inclusive.
  - Next state: MEM_LAT=1 goes to DONE; otherwise load the wait counter with MEM_LAT-2 and go to WAIT.
- WAIT:
  - mem_en=0, mem_we=0.
  - Decrement the counter each cycle; at 0, go to DONE.
  - WAIT lasts MEM_LAT-1 cycles total.
- Read capture: on the edge leaving the last ACCESS/WAIT cycle, rdata<=mem_rdata for reads; rdata is unchanged for writes.
- DONE (1 cycle):
  - The owner's done=1; gnt is still high.
  - Next state is always IDLE, so there is exactly one IDLE cycle between transactions.
- Latency: a req seen in IDLE at cycle 0 gives ACCESS in cycle 1 and done in cycle 1+MEM_LAT.
- mem_addr and mem_wdata hold their latched values from ACCESS until the next grant.
- Dropping req after the grant has no effect: the transaction completes and done is still pulsed.
- A req still high in the cycle after done is treated as a new request.
- The non-owner's req is ignored until IDLE; it is never lost, only delayed.
- gnt signals are mutually exclusive; both low in IDLE.
- Requester inputs are sampled only on the grant edge.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: on a tie, the CPU always wins; the owner register is still kept for debug, but arbitration ignores it.
- Undefined: round-robin as above.
- Single-requester behaviour and timing are identical in both builds.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding localparams: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3;
  - owner encoding: OWN_CPU=1'b0, OWN_IO=1'b1.
- One sub-module, arb_pick2: combinational two-requester winner select from {cpu_req, io_req, last_owner}. The MEM_ARB_FIXED_PRIO_EN switch lives inside it.
- The FSM, counter and registers stay in mem_arbiter.

Test Plan:
- Single CPU read, MEM_LAT=1, mem[0x10]=0xA5: cpu_req at cycle 0 -> ACCESS with mem_en=1 and mem_addr=0x10 at cycle 1; cpu_done=1 and rdata=0xA5 at cycle 2; busy low at cycle 3.
- I/O write, MEM_LAT=3, addr 0x22, data 0x5C: mem_we=1 only in the ACCESS cycle, WAIT lasts 2 cycles, io_done at cycle 4, mem[0x22]=0x5C; cpu_gnt stays 0 throughout.
- Both req held continuously after reset: grants alternate CPU, IO, CPU, IO, with one IDLE cycle between transactions. With MEM_ARB_FIXED_PRIO_EN defined: CPU every time while its req stays high.
- cpu_req dropped in the ACCESS cycle -> cpu_done still pulses at cycle 1+MEM_LAT; a pending io_req is granted in the following IDLE cycle.
- rst asserted in WAIT (MEM_LAT=4) -> mem_en, mem_we, gnt, done and busy go to 0 immediately, with no done pulse. After release, a new cpu_req completes normally and the CPU wins the first tie.
- I/O write 0x77 to addr 0x30, then CPU read of addr 0x30 -> rdata=0x77; rdata holds its value across a following write transaction.
